// File: rtl/wb_line_memory.sv
// Line-wide backing memory answering cyc/stb/we line requests from the L1 cache controller.
// Latency: request captured at edge T, ack_out (or err_out) high for the one cycle after edge T+LATENCY-1.
// Backpressure: single outstanding transfer; new requests are only captured in IDLE, ignored while busy.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   cyc_in, stb_in, we_in   bus cycle, strobe, write enable
//   adr_in                  byte address; line index taken above the in-line offset bits
//   sel_in, dat_in          write byte enables and write line data
//   dat_out, ack_out        read line data (held until the next read ack), one-cycle ack
//   err_out                 error response, only when WB_MEM_ERR_EN is defined
//
// Optional feature macro: WB_MEM_ERR_EN (misaligned address or empty-sel write -> err instead of ack).
module wb_line_memory #(
  parameter int LINE_W  = 128,
  parameter int ADDR_W  = 16,
  parameter int IDX_W   = 12,
  parameter int LATENCY = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cyc_in,
  input  logic                stb_in,
  input  logic                we_in,
  input  logic [ADDR_W-1:0]   adr_in,
  input  logic [LINE_W/8-1:0] sel_in,
  input  logic [LINE_W-1:0]   dat_in,
  output logic [LINE_W-1:0]   dat_out,
  output logic                ack_out
`ifdef WB_MEM_ERR_EN
  ,
  output logic                err_out
`endif
);

  localparam int NB  = LINE_W / 8;
  localparam int OFS = $clog2(NB);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [LINE_W-1:0]   dat_q;

  // Captured request; only meaningful while a transfer is in flight.
  logic [IDX_W-1:0]    idx_q;
  logic                we_q;
  logic [NB-1:0]       sel_q;
  logic [LINE_W-1:0]   wdat_q;
  logic                err_q;

  logic [LINE_W-1:0]   mem [2**IDX_W];

  logic                req;
  logic                capture;
  logic                commit;
  logic                err_live;
  logic [IDX_W-1:0]    idx_eff;
  logic                we_eff;
  logic [NB-1:0]       sel_eff;
  logic [LINE_W-1:0]   wdat_eff;
  logic                err_eff;
  logic                unused_adr;

  assign req     = cyc_in & stb_in;
  assign capture = (state_q == S_IDLE) & req;

`ifdef WB_MEM_ERR_EN
  assign err_live = (adr_in[OFS-1:0] != '0) | (we_in & (sel_in == '0));
`else
  assign err_live = 1'b0;
`endif

  // Offset bits (default build) and any bits above the index are deliberately dropped.
  assign unused_adr = ^adr_in;

  // With LATENCY==1 the response edge is the capture edge, so the live bus must
  // feed the commit directly instead of the (not yet loaded) capture registers.
  assign idx_eff  = capture ? adr_in[OFS +: IDX_W] : idx_q;
  assign we_eff   = capture ? we_in    : we_q;
  assign sel_eff  = capture ? sel_in   : sel_q;
  assign wdat_eff = capture ? dat_in   : wdat_q;
  assign err_eff  = capture ? err_live : err_q;

  // Memory and dat_out change on the edge that enters RESP; a reset on that edge wins.
  assign commit = rst_n & (state_d == S_RESP);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Abort takes priority over a response that would otherwise be due.
        if (!cyc_in)             state_d = S_IDLE;
        else if (cnt_q == 4'd1)  state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ack_out = (state_q == S_RESP) && !err_q;
`ifdef WB_MEM_ERR_EN
    err_out = (state_q == S_RESP) && err_q;
`endif
  end

  assign dat_out = dat_q;

  // Request capture; no reset needed, contents are only used after a capture.
  always_ff @(posedge clk) begin
    if (capture) begin
      idx_q  <= adr_in[OFS +: IDX_W];
      we_q   <= we_in;
      sel_q  <= sel_in;
      wdat_q <= dat_in;
      err_q  <= err_live;
    end
  end

  // Read data register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dat_q <= '0;
    end else if (commit && !we_eff && !err_eff) begin
      dat_q <= mem[idx_eff];
    end
  end

  // Backing store, never cleared by reset
  always_ff @(posedge clk) begin
    if (commit && we_eff && !err_eff) begin
      for (int b = 0; b < NB; b++) begin
        if (sel_eff[b]) mem[idx_eff][b*8 +: 8] <= wdat_eff[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_line_memory.sv
module tb_wb_line_memory;

  localparam logic [127:0] D0 = 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0;
  localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] D1P = 128'h0123_4567_89AB_CDEF_0011_2233_4455_BEEF;
  localparam logic [127:0] D2 = 128'hCAFE_F00D_DEAD_BEEF_0BAD_C0DE_1357_9BDF;
  localparam logic [127:0] D4 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] D5 = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         cyc, stb, we;
  logic [15:0]  adr, sel;
  logic [127:0] wdat, rdat;
  logic         ack, err_w;

  logic         cyc1, stb1, ack1;
  logic [127:0] rdat1;

  wb_line_memory u_dut (
    .clk(clk), .rst_n(rst_n), .cyc_in(cyc), .stb_in(stb), .we_in(we),
    .adr_in(adr), .sel_in(sel), .dat_in(wdat), .dat_out(rdat), .ack_out(ack)
`ifdef WB_MEM_ERR_EN
    , .err_out(err_w)
`endif
  );

`ifndef WB_MEM_ERR_EN
  assign err_w = 1'b0;
`else
  logic err1;
`endif

  wb_line_memory #(.LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .cyc_in(cyc1), .stb_in(stb1), .we_in(1'b1),
    .adr_in(16'h0000), .sel_in(16'hFFFF), .dat_in(D0), .dat_out(rdat1), .ack_out(ack1)
`ifdef WB_MEM_ERR_EN
    , .err_out(err1)
`endif
  );

  typedef struct {
    logic         rd;
    logic         err;
    logic [127:0] dat;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] model [int];
  logic [127:0] last_rd;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Pops one expectation per ack/err pulse, sampled mid-cycle.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (ack || err_w) begin
        chk("sb_nonempty", 128'(sb.size() > 0), 128'd1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("err_flag", 128'(err_w), 128'(e.err));
          if (e.err) begin
            chk("err_dat_hold", rdat, last_rd);
          end else if (e.rd) begin
            chk("rd_data", rdat, e.dat);
            last_rd = e.dat;
          end
        end
      end
    end
  endtask

  // Drives one transfer, records its expectation, checks ack latency and pulse width.
  task automatic issue(input logic w, input logic [15:0] a, input logic [15:0] s,
                       input logic [127:0] d, input int exp_lat);
    exp_t         e;
    int           idx;
    int           lat;
    logic [127:0] line;
    idx   = int'(a[15:4]);
    e.rd  = !w;
    e.err = 1'b0;
`ifdef WB_MEM_ERR_EN
    e.err = (a[3:0] != 4'h0) || (w && s == 16'h0000);
`endif
    line = model.exists(idx) ? model[idx] : '0;
    if (w && !e.err) begin
      for (int b = 0; b < 16; b++) if (s[b]) line[b*8 +: 8] = d[b*8 +: 8];
      model[idx] = line;
    end
    e.dat = line;
    sb.push_back(e);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; wdat = d;
    @(posedge clk); #1;
    stb = 1'b0;
    lat = 1;
    while (!(ack || err_w) && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 128'(lat), 128'(exp_lat));
    @(posedge clk); #1;
    chk("ack_pulse", 128'({ack, err_w}), 128'd0);
    cyc = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run still active, expected finish");
    $fatal(1);
  end

  initial begin
    int           acks;
    logic [5:0]   pat;
    logic [15:0]  a;
    logic [127:0] d;

    rst_n = 1'b0; cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h0000;
    sel = 16'hFFFF; wdat = D0; cyc1 = 1'b0; stb1 = 1'b0; last_rd = '0;
    fork
      monitor();
    join_none

    // Reset held with a live request: nothing may respond.
    repeat (2) begin
      @(negedge clk);
      chk("rst_ack", 128'(ack), 128'd0);
      chk("rst_dat", rdat, 128'd0);
    end
    rst_n = 1'b1;
    issue(1'b1, 16'h0000, 16'hFFFF, D0, 4);
    issue(1'b0, 16'h0000, 16'h0000, '0, 4);

    // Full write, read back, partial write, read back.
    issue(1'b1, 16'h0040, 16'hFFFF, D1, 4);
    issue(1'b0, 16'h0040, 16'h0000, '0, 4);
    chk("full_line", rdat, D1);
    issue(1'b1, 16'h0040, 16'h0003, 128'h0000_BEEF, 4);
    issue(1'b0, 16'h0040, 16'h0000, '0, 4);
    chk("partial_line", rdat, D1P);

    // Abort: cyc dropped during WAIT, no ack through T+8.
    issue(1'b1, 16'h0080, 16'hFFFF, D2, 4);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 16'h0080;
    @(posedge clk); #1; stb = 1'b0;
    @(posedge clk); #1; cyc = 1'b0;
    acks = 0;
    repeat (7) begin
      @(posedge clk); #1;
      acks += int'(ack);
    end
    chk("abort_noack", 128'(acks), 128'd0);
    @(negedge clk);
    issue(1'b0, 16'h0080, 16'h0000, '0, 4);

    // Reset mid-transfer: the write must not land and dat_out clears.
    issue(1'b1, 16'h00C0, 16'hFFFF, D4, 4);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'h00C0; sel = 16'hFFFF; wdat = D5;
    @(posedge clk); #1; stb = 1'b0;
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1; cyc = 1'b0;
    chk("midrst_dat", rdat, 128'd0);
    last_rd = '0;
    acks = 0;
    repeat (6) begin
      @(posedge clk); #1;
      acks += int'(ack);
    end
    chk("midrst_noack", 128'(acks), 128'd0);
    @(negedge clk);
    issue(1'b0, 16'h00C0, 16'h0000, '0, 4);

    // Randomised full then partial writes, each read back.
    for (int i = 0; i < 6; i++) begin
      a = 16'(((16 + i * 37) << 4));
      d = {$urandom, $urandom, $urandom, $urandom};
      issue(1'b1, a, 16'hFFFF, d, 4);
      d = {$urandom, $urandom, $urandom, $urandom};
      issue(1'b1, a, 16'($urandom_range(1, 65535)), d, 4);
      issue(1'b0, a, 16'h0000, '0, 4);
    end

`ifdef WB_MEM_ERR_EN
    issue(1'b1, 16'h0042, 16'hFFFF, D5, 4);
    issue(1'b0, 16'h0040, 16'h0000, '0, 4);
    chk("err_no_write", rdat, D1P);
    issue(1'b1, 16'h0040, 16'h0000, D5, 4);
    issue(1'b0, 16'h0041, 16'h0000, '0, 4);
    issue(1'b0, 16'h0040, 16'h0000, '0, 4);
`else
    // Empty-sel write is a no-op; offset bits are ignored.
    issue(1'b1, 16'h0080, 16'h0000, D5, 4);
    issue(1'b0, 16'h0085, 16'h0000, '0, 4);
    chk("ofs_ignored", rdat, D2);
`endif

    // LATENCY=1 instance with the request held: acks on alternate cycles.
    cyc1 = 1'b1; stb1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      pat[i] = ack1;
    end
    cyc1 = 1'b0; stb1 = 1'b0;
    chk("l1_pattern", 128'(pat), 128'(6'b010101));

    repeat (3) @(negedge clk);
    chk("sb_drained", 128'(sb.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
